ucontrol_nest: RTL
==================

UCONTROL_NEST -- requirements
Module: ucontrol_nest

Interface
REQ-001 SHALL take parameter UINST_ADDR_WIDTH, default 8, microcode address width.
REQ-002 SHALL take parameter CNT_WIDTH, default 11, loop-count width.
REQ-003 SHALL take parameter LOOP_DEPTH, default 4, maximum nested loops (power of 2, 2..16).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports start (input, 1, run pulse) and upc_start (input, UINST_ADDR_WIDTH, entry address).
REQ-007 SHALL have ports done (input, 1, end of program) and stall (input, 1, hold sequencer).
REQ-008 SHALL have ports loop_push (input, 1, open loop) and loop_count (input, CNT_WIDTH, iterations).
REQ-009 SHALL have port loop_end (input, 1), last instruction of the loop body.
REQ-010 SHALL have ports jmp_en (input, 1) and jmp_addr (input, UINST_ADDR_WIDTH), unconditional jump.
REQ-011 SHALL have ports upc (output, UINST_ADDR_WIDTH, registered micro-PC) and busy (output, 1, running).
REQ-012 SHALL have ports depth (output, $clog2(LOOP_DEPTH)+1, open loops) and err (output, 3, sticky {illegal, underflow, overflow}).

Function
REQ-013 SHALL implement two states, IDLE and RUN; IDLE->RUN on start, RUN->IDLE on done; busy=1 only in RUN.
REQ-014 SHALL apply per-cycle priority start > done > stall > (RUN control) > hold.
REQ-015 On start in any state: next upc=upc_start, stack cleared, depth=0, err cleared, state=RUN.
REQ-016 On done (no start): next upc=0, stack cleared, state=IDLE; err retained.
REQ-017 In RUN with stall=1: upc, stack, depth and err unchanged.
REQ-018 loop_push in RUN: push {body=upc+1, count=max(loop_count,1)}; next upc=upc+1; depth+1.
REQ-019 loop_end in RUN with depth>0: if top count>1, decrement top count and next upc=top body; else pop, depth-1, next upc=upc+1.
REQ-020 loop_count=N SHALL execute the body exactly N times; N=0 SHALL execute it once.
REQ-021 jmp_en in RUN with no push/end: next upc=jmp_addr; jmp_en with push or end SHALL be ignored (illegal).
REQ-022 Otherwise in RUN: next upc=upc+1, wrapping modulo 2^UINST_ADDR_WIDTH.
REQ-023 push at depth=LOOP_DEPTH: set err[0], no push, next upc=upc+1.
REQ-024 loop_end at depth=0: set err[1], next upc=upc+1.
REQ-025 push and end in the same cycle, or jmp_en with either: set err[2], no stack action, next upc=upc+1.
REQ-026 In IDLE, upc SHALL hold and control inputs other than start SHALL be ignored.
REQ-027 All state SHALL be registered; upc reflects a decision one cycle after the controlling inputs.

Reset
REQ-028 rstn low SHALL asynchronously force upc=0, state=IDLE, busy=0, depth=0, err=0, and all stack entries to 0.
REQ-029 Deassertion SHALL take effect on the next clk edge; a start in that cycle SHALL be honoured.

Structure
REQ-030 Shared package useq_pkg SHALL hold the state enum, the err bit indices and the default parameter constants.
REQ-031 Stack SHALL be sub-module useq_loop_stack (LIFO of {addr,count}, push/pop/dec_top, clear), LOOP_DEPTH entries.
REQ-032 No combinational path SHALL exist from any input to upc, busy, depth or err.

Verification
REQ-033 start, upc_start=0x10; push at 0x10 with count=3; end at 0x12 -> upc 0x10,11,12,11,12,11,12,13; depth 1->0.
REQ-034 Nested: outer count=2 at 0x20, inner count=2 at 0x21, inner end 0x22, outer end 0x23 -> inner body executes 4 times, depth peaks at 2, final upc 0x24.
REQ-035 LOOP_DEPTH=4, five pushes -> err=3'b001, depth=4; the following end -> normal loop-back.
REQ-036 Stall held 3 cycles mid-loop -> upc and depth frozen; sequence resumes identically.
REQ-037 done at upc 0x15 with depth=2 -> upc=0, busy=0, depth=0; rstn pulse mid-loop -> all outputs 0 immediately.
REQ-038 loop_count=0 -> body once; push+end same cycle -> err[2]=1; upc 0xFF increments to 0x00.

Source files
------------

// File: rtl/ucontrol_nest_pkg.sv
// Shared definitions for the nested-loop microcode sequencer.
// Holds the sequencer state enum, the sticky error bit positions and the
// default parameter values used by the interface, the top and the stack.
package useq_pkg;

  localparam int unsigned DefUinstAddrWidth = 8;
  localparam int unsigned DefCntWidth       = 11;
  localparam int unsigned DefLoopDepth      = 4;

  // Bit positions inside the 3-bit sticky err vector {illegal, underflow, overflow}.
  localparam int unsigned ErrOverflow  = 0;
  localparam int unsigned ErrUnderflow = 1;
  localparam int unsigned ErrIllegal   = 2;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } useq_state_e;

endpackage

// File: rtl/ucontrol_nest_if.sv
// Control/status bundle of the nested-loop microcode sequencer.
// master: the block issuing run/loop/jump controls and observing the micro-PC.
// slave : the sequencer itself.
// Controls: start/upc_start, done, stall, loop_push/loop_count, loop_end,
// jmp_en/jmp_addr. Status: upc, busy, depth, err.
interface ucontrol_nest_if
  import useq_pkg::*;
#(
  parameter int unsigned UINST_ADDR_WIDTH = DefUinstAddrWidth,
  parameter int unsigned CNT_WIDTH        = DefCntWidth,
  parameter int unsigned LOOP_DEPTH       = DefLoopDepth
) ();

  localparam int unsigned DepthW = $clog2(LOOP_DEPTH) + 1;

  logic                        start;
  logic [UINST_ADDR_WIDTH-1:0] upc_start;
  logic                        done;
  logic                        stall;
  logic                        loop_push;
  logic [CNT_WIDTH-1:0]        loop_count;
  logic                        loop_end;
  logic                        jmp_en;
  logic [UINST_ADDR_WIDTH-1:0] jmp_addr;
  logic [UINST_ADDR_WIDTH-1:0] upc;
  logic                        busy;
  logic [DepthW-1:0]           depth;
  logic [2:0]                  err;

  modport master (
    output start, upc_start, done, stall, loop_push, loop_count, loop_end, jmp_en, jmp_addr,
    input  upc, busy, depth, err
  );

  modport slave (
    input  start, upc_start, done, stall, loop_push, loop_count, loop_end, jmp_en, jmp_addr,
    output upc, busy, depth, err
  );

endinterface

// File: rtl/ucontrol_nest_loop_stack.sv
// LIFO of {body address, remaining count} for nested microcode loops.
// Ports: clk/rstn (async active-low), clear_i (empty and zero all entries),
// push_i with push_addr_i/push_cnt_i, pop_i, dec_top_i (decrement top count),
// top_addr_o/top_cnt_o (top entry), depth_o (entries in use).
// Priority clear > push > pop > dec_top; the caller guards against over/underflow.
module useq_loop_stack #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned CntWidth  = 11,
  parameter int unsigned Depth     = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   dec_top_i,
  input  logic [AddrWidth-1:0]   push_addr_i,
  input  logic [CntWidth-1:0]    push_cnt_i,
  output logic [AddrWidth-1:0]   top_addr_o,
  output logic [CntWidth-1:0]    top_cnt_o,
  output logic [$clog2(Depth):0] depth_o
);

  localparam int unsigned IdxW   = $clog2(Depth);
  localparam int unsigned DepthW = IdxW + 1;

  logic [AddrWidth-1:0] addr_q [Depth];
  logic [AddrWidth-1:0] addr_d [Depth];
  logic [CntWidth-1:0]  cnt_q  [Depth];
  logic [CntWidth-1:0]  cnt_d  [Depth];
  logic [DepthW-1:0]    depth_q, depth_d;
  logic [IdxW-1:0]      top_idx, wr_idx;

  // With an empty stack top_idx aliases the last entry; callers never use it then.
  assign top_idx = IdxW'(depth_q - DepthW'(1));
  assign wr_idx  = IdxW'(depth_q);

  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    if (clear_i) begin
      for (int i = 0; i < Depth; i++) begin
        addr_d[i] = '0;
        cnt_d[i]  = '0;
      end
      depth_d = '0;
    end else if (push_i) begin
      addr_d[wr_idx] = push_addr_i;
      cnt_d[wr_idx]  = push_cnt_i;
      depth_d        = depth_q + DepthW'(1);
    end else if (pop_i) begin
      depth_d = depth_q - DepthW'(1);
    end else if (dec_top_i) begin
      cnt_d[top_idx] = cnt_q[top_idx] - CntWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < Depth; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      depth_q <= '0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
    end
  end

  assign top_addr_o = addr_q[top_idx];
  assign top_cnt_o  = cnt_q[top_idx];
  assign depth_o    = depth_q;

endmodule

// File: rtl/ucontrol_nest.sv
// Nested-loop microcode sequencer.
// Ports: clk (rising edge), rstn (async active-low), bus (slave side of
// ucontrol_nest_if). start loads upc_start and enters RUN; done returns to IDLE.
// In RUN each cycle performs one of: loop push, loop end (loop back or pop),
// jump, or increment. Conflicting controls and stack over/underflow set
// sticky err bits and fall back to a plain increment. All outputs are flops.
module ucontrol_nest
  import useq_pkg::*;
#(
  parameter int unsigned UINST_ADDR_WIDTH = DefUinstAddrWidth,
  parameter int unsigned CNT_WIDTH        = DefCntWidth,
  parameter int unsigned LOOP_DEPTH       = DefLoopDepth
) (
  input  logic          clk,
  input  logic          rstn,
  ucontrol_nest_if.slave bus
);

  localparam int unsigned AW     = UINST_ADDR_WIDTH;
  localparam int unsigned CW     = CNT_WIDTH;
  localparam int unsigned DepthW = $clog2(LOOP_DEPTH) + 1;

  useq_state_e       state_q, state_d;
  logic [AW-1:0]     upc_q, upc_d;
  logic [2:0]        err_q, err_d;

  logic              stk_clear, stk_push, stk_pop, stk_dec;
  logic [CW-1:0]     push_cnt;
  logic [AW-1:0]     top_addr, upc_inc;
  logic [CW-1:0]     top_cnt;
  logic [DepthW-1:0] depth;
  logic              illegal;

  assign upc_inc  = upc_q + AW'(1);
  // A zero count still runs the body once.
  assign push_cnt = (bus.loop_count == '0) ? CW'(1) : bus.loop_count;
  assign illegal  = (bus.loop_push && bus.loop_end) ||
                    (bus.jmp_en && (bus.loop_push || bus.loop_end));

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    err_d     = err_q;
    stk_clear = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_dec   = 1'b0;
    if (bus.start) begin
      state_d   = StRun;
      upc_d     = bus.upc_start;
      err_d     = '0;
      stk_clear = 1'b1;
    end else if (state_q == StRun) begin
      if (bus.done) begin
        state_d   = StIdle;
        upc_d     = '0;
        stk_clear = 1'b1;
      end else if (!bus.stall) begin
        upc_d = upc_inc;
        if (illegal) begin
          err_d[ErrIllegal] = 1'b1;
        end else if (bus.loop_push) begin
          if (depth == DepthW'(LOOP_DEPTH)) begin
            err_d[ErrOverflow] = 1'b1;
          end else begin
            stk_push = 1'b1;
          end
        end else if (bus.loop_end) begin
          if (depth == '0) begin
            err_d[ErrUnderflow] = 1'b1;
          end else if (top_cnt > CW'(1)) begin
            stk_dec = 1'b1;
            upc_d   = top_addr;
          end else begin
            stk_pop = 1'b1;
          end
        end else if (bus.jmp_en) begin
          upc_d = bus.jmp_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      upc_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      err_q   <= err_d;
    end
  end

  useq_loop_stack #(
    .AddrWidth (AW),
    .CntWidth  (CW),
    .Depth     (LOOP_DEPTH)
  ) u_stack (
    .clk         (clk),
    .rstn        (rstn),
    .clear_i     (stk_clear),
    .push_i      (stk_push),
    .pop_i       (stk_pop),
    .dec_top_i   (stk_dec),
    .push_addr_i (upc_inc),
    .push_cnt_i  (push_cnt),
    .top_addr_o  (top_addr),
    .top_cnt_o   (top_cnt),
    .depth_o     (depth)
  );

  assign bus.upc   = upc_q;
  assign bus.busy  = (state_q == StRun);
  assign bus.depth = depth;
  assign bus.err   = err_q;

endmodule
